div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
Multi-cycle sequencer for the execute-stage divide resource. It accepts a DIV/DIVU request from the E stage and runs a radix-2 restoring division over WIDTH iterations. While it runs, it holds the pipeline through stall_div. It delivers a {remainder, quotient} pair in the same 64-bit format as the ALU's wide output, which the hilo register captures in M. It also aborts cleanly when the E stage is flushed.

Parameters:
WIDTH, 32, operand width in bits; result is 2*WIDTH bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  E-stage instruction is DIV/DIVU; level, held while stalled
signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled with start
cancel  input  1  E-stage flush; aborts any operation
opa  input  WIDTH  dividend (rs), post-forwarding
opb  input  WIDTH  divisor (rt), post-forwarding
stall_div  output  1  hold F/D/E pipeline registers
busy  output  1  state != IDLE
valid  output  1  result valid this cycle (single-cycle pulse)
result  output  2*WIDTH  {remainder (HI), quotient (LO)}

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, remainder/quotient registers=0. Outputs: result=0, valid=0, busy=0, stall_div=0.
- States: IDLE, BUSY, DONE.
- Transitions:
  - IDLE -> BUSY when start & ~cancel.
  - BUSY -> DONE when counter reaches WIDTH-1 and ~cancel.
  - DONE -> IDLE unconditionally.
  - Any state -> IDLE when cancel=1. Cancel has priority over all other transitions.
- IDLE, on start:
  - Latch |opa| and |opb| if signed_div, otherwise raw opa/opb.
  - Latch the quotient sign (opa[W-1]^opb[W-1]) & signed_div.
  - Latch the remainder sign opa[W-1] & signed_div.
  - Clear the counter.
- BUSY: one restoring step per cycle.
  - Shift {rem,quo} left by 1, then trial-subtract the divisor from the upper half.
  - If no borrow: commit the difference and set quo[0]=1. Otherwise keep the value and set quo[0]=0.
  - The counter increments each cycle; exactly WIDTH BUSY cycles.
- DONE:
  - Apply sign fix (two's-complement negate) to the quotient and/or remainder per the latched signs.
  - Drive result, valid=1, stall_div=0.
  - start is ignored in DONE, because the same instruction is still presented while it advances.
- stall_div is combinational: (state==IDLE & start & ~cancel) | (state==BUSY & ~cancel).
  - Total stall for one divide: WIDTH+1 cycles. The instruction leaves E in the DONE cycle.
- Back-to-back divides: the second start is seen in the IDLE cycle after DONE and begins normally.
- result holds its last DONE value until the next DONE. Consumers qualify it with valid only.
- Divide by zero (opb==0):
  - Result is quotient = all-ones and remainder = opa (raw, no sign fix), in either mode.
  - Timing is the normal WIDTH+1 stall cycles.
- Signed overflow (opa = most negative value, opb = -1): quotient = 0x80000000, remainder = 0. This falls out of the magnitude algorithm with no special case.
- Cancel in BUSY or DONE: valid is never pulsed for the cancelled operation, and stall_div drops in the same cycle.
- A cancel coinciding with a new start in IDLE drops that start.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values.

Optional Feature:
DIV_ZERO_FAST_EN.
- Defined: if opb==0 at start in IDLE, go IDLE -> DONE directly. stall_div is asserted for that one cycle only, and the result is the divide-by-zero value in the next cycle.
- Undefined: divide by zero takes the full WIDTH-iteration path. The result value is identical in both builds.

Test Plan:
- DIVU, opa=100, opb=7 -> stall_div high exactly 33 cycles; DONE: valid=1, result={32'd2, 32'd14}.
- DIV, opa=-7 (0xFFFFFFF9), opb=2 -> result={0xFFFFFFFF, 0xFFFFFFFD}, i.e. rem=-1, quo=-3.
- DIV, opa=0x80000000, opb=0xFFFFFFFF -> result={0x00000000, 0x80000000}, no hang.
- DIVU, opa=0x1234, opb=0 -> result={0x00001234, 0xFFFFFFFF}. Stall is 33 cycles without the macro and 1 cycle with DIV_ZERO_FAST_EN.
- Cancel mid-divide:
  - Start DIVU 50/5, assert cancel on the 10th BUSY cycle -> stall_div=0 the same cycle, IDLE next cycle, no valid pulse, result unchanged.
  - Then a new DIVU 9/4 -> result={1, 2}.
- Reset mid-divide: pull rst low on the 5th BUSY cycle -> busy, stall_div, valid and result all 0 asynchronously.
  - After release: back-to-back DIVU 10/3 then 20/6 -> {1, 3} then {2, 3}, with the second start accepted in the IDLE cycle after the first DONE.

Source files
------------

// File: rtl/div_seq_if.sv
// Request/response bundle between the E stage and the divide sequencer.
interface div_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 start;
  logic                 signed_div;
  logic                 cancel;
  logic [WIDTH-1:0]     opa;
  logic [WIDTH-1:0]     opb;
  logic                 stall_div;
  logic                 busy;
  logic                 valid;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, signed_div, cancel, opa, opb,
    input  stall_div, busy, valid, result
  );

  modport slave (
    input  start, signed_div, cancel, opa, opb,
    output stall_div, busy, valid, result
  );
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring DIV/DIVU sequencer producing {remainder, quotient}.
// Optional macro DIV_ZERO_FAST_EN: divide by zero skips the iteration loop.
module div_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, stateNext;
  logic [CNT_W-1:0]     count;
  logic [WIDTH-1:0]     remReg, quoReg, divisor;
  logic                 quoNeg, remNeg;
  logic [2*WIDTH-1:0]   resultHold;

  logic                 accept, lastStep, divZero, noBorrow;
  logic [WIDTH-1:0]     opaAbs, opbAbs, remStep, quoStep, remFix, quoFix;
  logic [WIDTH:0]       shifted;

  // Operand conditioning, one restoring step, and the final sign fix.
  always_comb begin
    opaAbs   = (bus.signed_div && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
    opbAbs   = (bus.signed_div && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;
    divZero  = (bus.opb == '0);
    shifted  = {remReg, quoReg[WIDTH-1]};
    noBorrow = (shifted >= {1'b0, divisor});
    remStep  = noBorrow ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
    quoStep  = {quoReg[WIDTH-2:0], noBorrow};
    quoFix   = quoNeg ? -quoReg : quoReg;
    remFix   = remNeg ? -remReg : remReg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Next state and handshake outputs; cancel overrides every transition.
  always_comb begin
    stateNext     = state;
    accept        = 1'b0;
    lastStep      = (count == CNT_W'(WIDTH - 1));
    bus.stall_div = 1'b0;
    bus.valid     = 1'b0;
    bus.busy      = (state != IDLE);
    bus.result    = resultHold;
    case (state)
      IDLE: begin
        if (bus.start && !bus.cancel && rst) begin
          accept        = 1'b1;
          bus.stall_div = 1'b1;
          stateNext     = BUSY;
`ifdef DIV_ZERO_FAST_EN
          if (divZero) stateNext = DONE;
`endif
        end
      end
      BUSY: begin
        if (bus.cancel) begin
          stateNext = IDLE;
        end else begin
          bus.stall_div = 1'b1;
          if (lastStep) stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
        if (!bus.cancel) begin
          bus.valid  = 1'b1;
          bus.result = {remFix, quoFix};
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: a zero divisor loads the raw dividend with no sign fix so the
  // loop naturally yields quotient=all-ones, remainder=opa.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      remReg     <= '0;
      quoReg     <= '0;
      divisor    <= '0;
      quoNeg     <= 1'b0;
      remNeg     <= 1'b0;
      resultHold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            count <= '0;
            if (divZero) begin
              divisor <= '0;
              quoNeg  <= 1'b0;
              remNeg  <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
              remReg  <= bus.opa;
              quoReg  <= '1;
`else
              remReg  <= '0;
              quoReg  <= bus.opa;
`endif
            end else begin
              remReg  <= '0;
              quoReg  <= opaAbs;
              divisor <= opbAbs;
              quoNeg  <= bus.signed_div & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
              remNeg  <= bus.signed_div & bus.opa[WIDTH-1];
            end
          end
        end
        BUSY: begin
          remReg <= remStep;
          quoReg <= quoStep;
          count  <= count + CNT_W'(1);
        end
        DONE: begin
          if (!bus.cancel) resultHold <= {remFix, quoFix};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: vector table plus cancel/reset sequences.
module tb_div_seq;

  localparam int unsigned WIDTH = 32;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_STALLS = 1;
`else
  localparam int ZERO_STALLS = 33;
`endif

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          stalls;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  div_seq_if #(.WIDTH(WIDTH)) bus ();

  div_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one divide and hold start until the DONE cycle; counts stall cycles.
  task automatic runDiv(input string name, input vec_t v);
    int stalls = 0;
    bit seen = 1'b0;
    bus.start      = 1'b1;
    bus.signed_div = v.sgn;
    bus.opa        = v.a;
    bus.opb        = v.b;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (bus.stall_div) stalls++;
      if (bus.valid) begin
        seen = 1'b1;
        check({name, " result"}, bus.result, v.exp);
        check({name, " stalls"}, 64'(stalls), 64'(v.stalls));
      end
      @(posedge clk); #1;
    end
    if (!seen) check({name, " timeout"}, 64'(0), 64'(1));
    check({name, " pulse"}, 64'(bus.valid), 64'(0));
    bus.start = 1'b0;
  endtask

  vec_t vecs [9];
  logic [63:0] heldResult;
  int validCount;

  initial begin
    vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},        33};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33};
    vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'h0,        32'h8000_0000}, 33};
    vecs[3] = '{1'b0, 32'h0000_1234,  32'd0,        {32'h0000_1234, 32'hFFFF_FFFF}, ZERO_STALLS};
    vecs[4] = '{1'b1, 32'hFFFF_FFF9,  32'd0,        {32'hFFFF_FFF9, 32'hFFFF_FFFF}, ZERO_STALLS};
    vecs[5] = '{1'b1, 32'd7,          32'hFFFF_FFFE, {32'd1,        32'hFFFF_FFFD}, 33};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        {32'd0,        32'hFFFF_FFFF}, 33};
    vecs[7] = '{1'b0, 32'd5,          32'd10,       {32'd5,        32'd0},         33};
    vecs[8] = '{1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'd2},        33};

    bus.start = 1'b0; bus.signed_div = 1'b0; bus.cancel = 1'b0;
    bus.opa = '0; bus.opb = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy",   64'(bus.busy),      64'(0));
    check("reset stall",  64'(bus.stall_div), 64'(0));
    check("reset valid",  64'(bus.valid),     64'(0));
    check("reset result", bus.result,         64'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 9; i++) runDiv($sformatf("vec%0d", i), vecs[i]);

    // Cancel on the 10th BUSY cycle of DIVU 50/5.
    heldResult = vecs[8].exp;
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opa = 32'd50; bus.opb = 32'd5;
    repeat (10) @(posedge clk);
    #1;
    check("busy before cancel",  64'(bus.busy),      64'(1));
    check("stall before cancel", 64'(bus.stall_div), 64'(1));
    bus.cancel = 1'b1; bus.start = 1'b0;
    #1;
    check("cancel stall drop", 64'(bus.stall_div), 64'(0));
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    check("cancel idle", 64'(bus.busy), 64'(0));
    validCount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.valid) validCount++;
    end
    check("cancel no valid",    64'(validCount), 64'(0));
    check("cancel result held", bus.result,      heldResult);
    @(posedge clk); #1;
    runDiv("after cancel 9/4", '{1'b0, 32'd9, 32'd4, {32'd1, 32'd2}, 33});

    // Asynchronous reset on the 5th BUSY cycle, start still asserted.
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opa = 32'd50; bus.opb = 32'd5;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid reset busy",   64'(bus.busy),      64'(0));
    check("mid reset stall",  64'(bus.stall_div), 64'(0));
    check("mid reset valid",  64'(bus.valid),     64'(0));
    check("mid reset result", bus.result,         64'(0));
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    runDiv("b2b 10/3", '{1'b0, 32'd10, 32'd3, {32'd1, 32'd3}, 33});
    runDiv("b2b 20/6", '{1'b0, 32'd20, 32'd6, {32'd2, 32'd3}, 33});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
